// File: rtl/phase_sched_if.sv
// phase_sched_if: control and status bundle of the phase sequencer.
// master drives run control, slave is the sequencer itself.
interface phase_sched_if #(
  parameter int CW     = 8,
  parameter int NTAP   = 2,
  parameter int ITER_W = 16
);
  logic              en;
  logic              start;
  logic              mode;
  logic [ITER_W-1:0] n_iter;
  logic              abort;
  logic [CW-1:0]     count;
  logic [ITER_W-1:0] iter;
  logic [NTAP-1:0]   tap_rst;
  logic              frame_start;
  logic              busy;
  logic              done;

  modport master (
    output en, start, mode, n_iter, abort,
    input  count, iter, tap_rst,
    input  frame_start, busy, done
  );

  modport slave (
    input  en, start, mode, n_iter, abort,
    output count, iter, tap_rst,
    output frame_start, busy, done
  );
endinterface

// File: rtl/phase_sched.sv
// phase_sched: phase counter with run/flush/abort sequencing and
// registered per-tap reset strobes for the downstream pipelines.
module phase_sched #(
  parameter int                 PERIOD  = 91,
  parameter int                 CW      = 8,
  parameter int                 NTAP    = 2,
  parameter logic [CW*NTAP-1:0] TAP_OFF = {8'd0, 8'd4},
  parameter int                 FLUSH   = 8,
  parameter int                 ITER_W  = 16
) (
  input logic          clk,
  input logic          rst,
  phase_sched_if.slave bus
);
  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [FW-1:0] FLAST = FW'(FLUSH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLSH} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [ITER_W-1:0] iter, iter_n;
  logic [ITER_W-1:0] niter_q, niter_n;
  logic              mode_q, mode_n;
  logic [NTAP-1:0]   tap, tap_n, hit;
  logic [FW-1:0]     fcnt, fcnt_n;
  logic              done, done_n;
  logic              wrap;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NTAP; k++)
      hit[k] = (count == TAP_OFF[k*CW +: CW]);
  end

  assign wrap = (count == LAST);

  always_comb begin
    state_n = state;
    count_n = count;
    iter_n  = iter;
    mode_n  = mode_q;
    niter_n = niter_q;
    tap_n   = tap;
    fcnt_n  = fcnt;
    done_n  = 1'b0;
    // abort ignores en; iter is left for readback
    if (bus.abort) begin
      state_n = IDLE;
      count_n = '0;
      tap_n   = '1;
    end else if (bus.en) begin
      unique case (state)
        IDLE: if (bus.start) begin
          mode_n  = bus.mode;
          niter_n = bus.n_iter;
          count_n = '0;
          iter_n  = '0;
          if (!bus.mode && bus.n_iter == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            tap_n   = '0;
          end
        end
        RUN: begin
          count_n = wrap ? '0 : count + CW'(1);
          tap_n   = hit;
          if (wrap) begin
            iter_n = iter + ITER_W'(1);
            if (!mode_q && iter == niter_q - ITER_W'(1)) begin
              state_n = FLSH;
              count_n = '0;
              tap_n   = '0;
              fcnt_n  = '0;
            end
          end
        end
        FLSH: begin
          if (fcnt == FLAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
            tap_n   = '1;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      iter    <= '0;
      mode_q  <= 1'b0;
      niter_q <= '0;
      tap     <= '1;
      fcnt    <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      iter    <= iter_n;
      mode_q  <= mode_n;
      niter_q <= niter_n;
      tap     <= tap_n;
      fcnt    <= fcnt_n;
      done    <= done_n;
    end
  end

  assign bus.count       = count;
  assign bus.iter        = iter;
  assign bus.tap_rst     = tap;
  assign bus.done        = done;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_start = (state == RUN) && (count == '0);
endmodule
